kanagawa_delay_credit_buffer: RTL and testbench
===============================================

Name: kanagawa_delay_credit_buffer

Overview:
- Downstream companion to the fixed-delay FIFO, which cannot stall. It restores ready/valid backpressure at that FIFO's output.
- The block grants issue credits to the producer feeding the delay line. It captures every item emerging from the delay line into local storage and presents the items to a consumer with valid/ready.
- Credits guarantee that storage can never overflow, however long the consumer stalls.

Parameters:
- WIDTH, 16, data width in bits.
- DEPTH, 16, storage entries; also the initial credit count; must be >= 1.
- DELAY, 8, delay of the upstream delay line in cycles. Used only for the throughput check below; no logic depends on it.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- issue_valid  in  1  producer is pushing one item into the delay line this cycle.
- issue_ready  out  1  a credit is available.
- pipe_valid  in  1  an item emerges from the delay line this cycle.
- pipe_data  in  WIDTH  delay line output data.
- out_valid  out  1  storage non-empty.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  WIDTH  head entry.
- overflow_err  out  1  sticky; set when pipe_valid arrives with storage full.

Behaviour:
- Reset: rst sampled low at posedge gives the following state, and this state holds while rst is low:
  - credits = DEPTH, occupancy = 0, read/write pointers = 0;
  - issue_ready = 1, out_valid = 0, overflow_err = 0;
  - out_data don't-care.
- Reset mid-operation discards all stored and in-flight items. The producer and delay line must be reset together.
- Issue handshake:
  - issue_fire = issue_valid & issue_ready.
  - issue_ready = (credits != 0), combinational from the credit register only.
  - issue_valid while issue_ready = 0 is ignored; credits are unchanged.
- Pop: pop = out_valid & out_ready. out_valid = (occupancy != 0). out_data is the head entry, driven from registered/RAM read state; no combinational path from pipe_data.
- Credit update: credits_next = credits - issue_fire + pop.
  - Simultaneous fire and pop leaves credits unchanged.
  - Credit width is $clog2(DEPTH+1).
  - credits never exceeds DEPTH and never underflows.
- Capture:
  - pipe_valid writes pipe_data at the write pointer on the posedge.
  - The item becomes visible on out_valid/out_data the following cycle. Latency from pipe_valid to out_valid is 1 cycle; there is no bypass.
- Occupancy: occupancy_next = occupancy + pipe_valid - pop. Simultaneous write and pop is legal at any occupancy, including full.
- Overflow:
  - pipe_valid with occupancy == DEPTH and no pop: the write is dropped and overflow_err sets. overflow_err clears only on reset.
  - This condition indicates a protocol violation by the producer.
- Pointers wrap modulo DEPTH. Non-power-of-two DEPTH is supported via explicit compare-and-clear.
- Throughput:
  - Credit round trip is issue, then DELAY cycles, then capture (+1), then pop, then credit return (+1).
  - Sustained 1 item/cycle requires DEPTH >= DELAY + 3. With smaller DEPTH the block still operates correctly at reduced rate.
  - An elaboration-time warning is emitted when DEPTH < DELAY + 3.

Optional Feature:
- Macro KANAGAWA_CREDIT_BUFFER_STATS_EN.
- When defined:
  - adds output port high_water (width $clog2(DEPTH+1)), the maximum occupancy since reset, reset value 0;
  - adds output port stall_cycles (32 bits), which counts cycles with out_valid & !out_ready and saturates at all-ones, reset value 0.
- When undefined, neither port nor its logic exists. Functional behaviour is identical either way.

Decomposition:
- Shared package kanagawa_credit_buffer_pkg:
  - count_width function, $clog2(DEPTH+1);
  - pointer width function;
  - stats counter width constant, 32.
- One sub-module, kanagawa_credit_buffer_storage: DEPTH x WIDTH storage with one write port and one synchronous read port, plus pointer wrap.
- Credit, occupancy and error logic stay in the top module.

Test Plan (WIDTH=16, DELAY=8 unless stated; the DUT is driven by a real fixed-delay FIFO instance):
- Reset: hold rst low 10 cycles, then release -> issue_ready=1, out_valid=0, overflow_err=0. credits internal = DEPTH (16).
- Streaming, DEPTH=11, out_ready=1: issue_valid=1 continuously, data 0..1023 -> issue_ready stays 1 throughout. out_data sequence is 0..1023 in order, with first out_valid 10 cycles after first issue.
- Backpressure, DEPTH=16: out_ready=0, issue_valid=1 -> exactly 16 issues accepted, then issue_ready=0. out_valid=1 with head=0, and no overflow_err. Then out_ready=1 -> 16 items 0..15 drain, and issue_ready returns 1 the cycle after the first pop.
- Simultaneous events, storage full: issue and pop in the same cycle -> credits unchanged. pipe_valid and pop in the same cycle -> occupancy stays 16 and data order is preserved.
- Protocol violation: force pipe_valid with occupancy 16 and out_ready=0 -> item dropped, overflow_err=1 and held. A reset clears it to 0.
- Reset mid-stream: assert rst with 5 items stored -> the next cycle shows out_valid=0 and issue_ready=1. After release, a new stream starting at 100 emerges as 100,101,...

Source files
------------

// File: rtl/kanagawa_credit_buffer_pkg.sv
// Shared sizing helpers for the kanagawa delay credit buffer.
// Optional statistics are enabled with KANAGAWA_CREDIT_BUFFER_STATS_EN.
package kanagawa_credit_buffer_pkg;

  localparam int STATS_WIDTH = 32;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/kanagawa_credit_buffer_storage.sv
// DEPTH x WIDTH circular storage: one write port, one registered read port.
// The read register always holds the entry the read pointer will point at.
module kanagawa_credit_buffer_storage
  import kanagawa_credit_buffer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_next;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign rd_ptr_next = rd_en ? wrap_inc(rd_ptr) : rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wrap_inc(wr_ptr);
      rd_ptr <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Write-first forwarding when the next head slot is written this edge.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_ptr == rd_ptr_next))
      rd_data <= wr_data;
    else
      rd_data <= mem[rd_ptr_next];
  end

endmodule

// File: rtl/kanagawa_delay_credit_buffer.sv
// Credit-managed capture buffer restoring backpressure after a delay line.
// KANAGAWA_CREDIT_BUFFER_STATS_EN adds high_water and stall_cycles.
module kanagawa_delay_credit_buffer
  import kanagawa_credit_buffer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int DELAY = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             pipe_valid,
  input  logic [WIDTH-1:0] pipe_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow_err
`ifdef KANAGAWA_CREDIT_BUFFER_STATS_EN
  ,
  output logic [count_width(DEPTH)-1:0] high_water,
  output logic [STATS_WIDTH-1:0]        stall_cycles
`endif
);

  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 1) begin : g_depth_chk
    $error("kanagawa_delay_credit_buffer: DEPTH must be >= 1");
  end

  if (DEPTH < DELAY + 3) begin : g_rate_chk
    $warning("kanagawa_delay_credit_buffer: DEPTH < DELAY+3, reduced rate");
  end

  logic [CW-1:0] credits;
  logic [CW-1:0] occupancy;
  logic          full;
  logic          issue_fire;
  logic          pop;
  logic          wr_en;

  assign issue_ready = (credits != '0);
  assign out_valid   = (occupancy != '0);
  assign full        = (occupancy == FULL);
  assign issue_fire  = issue_valid & issue_ready;
  assign pop         = out_valid & out_ready;
  assign wr_en       = pipe_valid & (~full | pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      credits      <= FULL;
      occupancy    <= '0;
      overflow_err <= 1'b0;
    end else begin
      credits   <= credits - CW'(issue_fire) + CW'(pop);
      occupancy <= occupancy + CW'(wr_en) - CW'(pop);
      // Arrival at full storage means the producer ignored credits.
      if (pipe_valid & full & ~pop) overflow_err <= 1'b1;
    end
  end

  kanagawa_credit_buffer_storage #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_storage (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data(pipe_data),
    .rd_en  (pop),
    .rd_data(out_data)
  );

`ifdef KANAGAWA_CREDIT_BUFFER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      high_water   <= '0;
      stall_cycles <= '0;
    end else begin
      if (occupancy > high_water) high_water <= occupancy;
      if (out_valid & ~out_ready & ~&stall_cycles)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_kanagawa_delay_credit_buffer.sv
// Bench: two buffers (DEPTH 16 and 11) fed by bench-side delay lines,
// checked against a queue-based reference model.
module tb_kanagawa_delay_credit_buffer;

  localparam int W   = 16;
  localparam int DEL = 8;
  localparam int DA  = 16;
  localparam int DB  = 11;
  localparam int NB  = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         iv_a, ir_a, pv_a, ov_a, or_a, oe_a;
  logic [W-1:0] pd_a, od_a;
  logic         iv_b, ir_b, pv_b, ov_b, or_b, oe_b;
  logic [W-1:0] pd_b, od_b;

  // Delay lines: issue registered, then DELAY cycles to the output.
  logic         dl_va [DEL+1];
  logic [W-1:0] dl_da [DEL+1];
  logic         dl_vb [DEL+1];
  logic [W-1:0] dl_db [DEL+1];
  logic         inj;
  logic [W-1:0] inj_data;

  assign pv_a = dl_va[DEL] | inj;
  assign pd_a = inj ? inj_data : dl_da[DEL];
  assign pv_b = dl_vb[DEL];
  assign pd_b = dl_db[DEL];

  kanagawa_delay_credit_buffer #(
    .WIDTH(W), .DEPTH(DA), .DELAY(DEL)
  ) dut_a (
    .clk(clk), .rst(rst),
    .issue_valid(iv_a), .issue_ready(ir_a),
    .pipe_valid(pv_a), .pipe_data(pd_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
    .overflow_err(oe_a)
  );

  kanagawa_delay_credit_buffer #(
    .WIDTH(W), .DEPTH(DB), .DELAY(DEL)
  ) dut_b (
    .clk(clk), .rst(rst),
    .issue_valid(iv_b), .issue_ready(ir_b),
    .pipe_valid(pv_b), .pipe_data(pd_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
    .overflow_err(oe_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model for instance A
  int           m_cred;
  logic [W-1:0] m_q [$];
  bit           m_ovf;
  logic [W-1:0] next_a;

  // stream bookkeeping for instance B
  bit           b_run;
  logic         rdy_b;
  logic [W-1:0] next_b, exp_b;
  int           sent_b, recv_b;
  int           first_issue_b, first_out_b;
  int           cyc;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit fa, pa, fb;
    fa = 0; pa = 0; fb = 0;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      m_cred = DA;
      m_q.delete();
      m_ovf = 0;
    end else begin
      fa = iv_a && (m_cred != 0);
      pa = or_a && (m_q.size() != 0);
      if (pa) void'(m_q.pop_front());
      if (pv_a) begin
        if (m_q.size() == DA) m_ovf = 1;
        else m_q.push_back(pd_a);
      end
      m_cred = m_cred - int'(fa) + int'(pa);
      fb = iv_b && rdy_b;
      if (fb) begin
        if (first_issue_b < 0) first_issue_b = cyc - 1;
        sent_b++;
      end
    end
    #1;
    for (int i = DEL; i > 0; i--) begin
      dl_va[i] = dl_va[i-1];
      dl_da[i] = dl_da[i-1];
      dl_vb[i] = dl_vb[i-1];
      dl_db[i] = dl_db[i-1];
    end
    dl_va[0] = fa;
    dl_da[0] = next_a;
    dl_vb[0] = fb;
    dl_db[0] = next_b;
    if (fa) next_a++;
    if (fb) next_b++;
    if (!rst) begin
      for (int i = 0; i <= DEL; i++) begin
        dl_va[i] = 0;
        dl_vb[i] = 0;
      end
    end
    inj = 0;
    chk("a_issue_ready", ir_a, m_cred != 0);
    chk("a_out_valid", ov_a, m_q.size() != 0);
    chk("a_overflow", oe_a, m_ovf);
    if (m_q.size() != 0) chk("a_out_data", od_a, m_q[0]);
    if (b_run && rst) begin
      if (sent_b < NB) chk("b_issue_ready", ir_b, 1);
      if (ov_b) begin
        if (first_out_b < 0) first_out_b = cyc;
        chk("b_out_data", od_b, exp_b);
        exp_b++;
        recv_b++;
      end
    end
    rdy_b = ir_b;
    iv_b  = b_run && (sent_b < NB);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit seen;
    rst = 0; iv_a = 0; or_a = 0; iv_b = 0; or_b = 1;
    inj = 0; inj_data = '0; next_a = '0; next_b = '0;
    exp_b = '0; sent_b = 0; recv_b = 0; b_run = 0; rdy_b = 0;
    first_issue_b = -1; first_out_b = -1; cyc = 0;
    m_cred = DA; m_ovf = 0;
    for (int i = 0; i <= DEL; i++) begin
      dl_va[i] = 0; dl_da[i] = '0;
      dl_vb[i] = 0; dl_db[i] = '0;
    end

    repeat (10) tick();
    rst = 1;
    tick();
    chk("rst_issue_ready", ir_a, 1);
    chk("rst_out_valid", ov_a, 0);

    // DEPTH=11 full-rate stream
    b_run = 1;
    iv_b = 1;
    for (int i = 0; i < 1300 && recv_b < NB; i++) tick();
    b_run = 0;
    iv_b = 0;
    chk("b_count", recv_b, NB);
    chk("b_latency", first_out_b - first_issue_b, 10);
    chk("b_overflow", oe_b, 0);

    // backpressure on DEPTH=16
    iv_a = 1; or_a = 0; acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (ir_a) acc++;
      tick();
    end
    chk("bp_accepted", acc, 16);
    chk("bp_issue_ready", ir_a, 0);
    chk("bp_head", od_a, 0);
    chk("bp_overflow", oe_a, 0);
    iv_a = 0; or_a = 1;
    tick();
    chk("bp_credit_return", ir_a, 1);
    repeat (15) tick();
    chk("bp_drained", ov_a, 0);

    // refill, then simultaneous events at full
    iv_a = 1; or_a = 0;
    repeat (30) tick();
    iv_a = 1; or_a = 1;
    tick();
    tick();
    chk("sim_issue_pop", ir_a, 1);
    iv_a = 0; or_a = 0;
    repeat (12) tick();
    inj = 1; inj_data = 16'hBEEF;
    tick();
    inj = 1; inj_data = 16'hCAFE; or_a = 1;
    tick();
    chk("sim_full_keep", ov_a, 1);
    chk("sim_no_ovf", oe_a, 0);
    or_a = 0; inj = 1; inj_data = 16'hDEAD;
    tick();
    chk("ovf_set", oe_a, 1);
    repeat (5) tick();
    chk("ovf_held", oe_a, 1);
    or_a = 1;
    repeat (4) tick();
    or_a = 0;
    rst = 0;
    tick();
    chk("ovf_cleared", oe_a, 0);
    rst = 1;
    tick();

    // reset with 5 items stored
    iv_a = 1;
    repeat (5) tick();
    iv_a = 0;
    repeat (12) tick();
    chk("mid_stored", ov_a, 1);
    rst = 0;
    tick();
    chk("mid_rst_valid", ov_a, 0);
    chk("mid_rst_ready", ir_a, 1);
    rst = 1;
    next_a = 16'd100;
    iv_a = 1; or_a = 1; seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ov_a && !seen) begin
        chk("mid_first", od_a, 100);
        seen = 1;
      end
    end
    chk("mid_seen", seen, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      iv_a = ($urandom_range(0, 3) != 0);
      or_a = ($urandom_range(0, 2) != 0);
      tick();
    end
    iv_a = 0; or_a = 1;
    repeat (30) tick();
    chk("rand_drained", ov_a, 0);
    chk("rand_credits", ir_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
